// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default: dcache wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              icache_gnt,
  output logic              dcache_gnt,
  output logic              icache_done,
  output logic              dcache_done,
  output logic [LINE_W-1:0] icache_rdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state;
  state_t            nxt;
  logic [3:0]        cnt;
  logic              last_gnt;
  logic              pick_d;
  logic              start;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = dcache_req && (!icache_req || !last_gnt);
`else
  assign pick_d = dcache_req;
`endif

  assign start = (state == IDLE) && (icache_req || dcache_req);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_d)          nxt = GNT_D;
        else if (icache_req) nxt = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (cnt == 4'd0) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    icache_gnt  = (state == GNT_I);
    dcache_gnt  = (state == GNT_D);
    mem_req     = icache_gnt || dcache_gnt;
    icache_done = (state == DONE) && !last_gnt;
    dcache_done = (state == DONE) && last_gnt;
    mem_we      = mem_req && we_q;
    mem_addr    = mem_req ? addr_q : '0;
    mem_wdata   = mem_req ? wdata_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // last_gnt doubles as the owner of the DONE cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= '0;
      last_gnt     <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      icache_rdata <= '0;
      dcache_rdata <= '0;
    end else if (start) begin
      cnt      <= CNT_INIT;
      last_gnt <= pick_d;
      addr_q   <= pick_d ? dcache_addr : icache_addr;
      we_q     <= pick_d && dcache_we;
      wdata_q  <= pick_d ? dcache_wdata : '0;
    end else if (mem_req) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (!we_q) begin
        if (icache_gnt) icache_rdata <= mem_rdata;
        else            dcache_rdata <= mem_rdata;
      end
    end
  end

endmodule
